// File: rtl/nv_nvdla_sdp_rdma_req_gen_if.sv
// rtl/nv_nvdla_sdp_rdma_req_gen_if.sv - DMA read-request and context-queue handshake bundle
// master drives requests/context entries, slave returns the ready signals.
interface nv_nvdla_sdp_rdma_req_gen_if #(
   parameter int AW = 64,
   parameter int BW = 3
);
   logic          dma_rd_req_vld;
   logic          dma_rd_req_rdy;
   logic [AW-1:0] dma_rd_req_addr;
   logic [BW-1:0] dma_rd_req_size;
   logic          ig2cq_pvld;
   logic          ig2cq_prdy;
   logic [BW:0]   ig2cq_pd;

   modport master (
      output dma_rd_req_vld, dma_rd_req_addr, dma_rd_req_size, ig2cq_pvld, ig2cq_pd,
      input  dma_rd_req_rdy, ig2cq_prdy
   );

   modport slave (
      input  dma_rd_req_vld, dma_rd_req_addr, dma_rd_req_size, ig2cq_pvld, ig2cq_pd,
      output dma_rd_req_rdy, ig2cq_prdy
   );
endinterface

// File: rtl/nv_nvdla_sdp_rdma_req_gen.sv
// rtl/nv_nvdla_sdp_rdma_req_gen.sv - SDP operand read-request generator with credit tracking
// Optional feature macro: SDP_RDMA_4K_SPLIT_EN (requests never cross a 4 KB boundary).
module nv_nvdla_sdp_rdma_req_gen #(
   parameter int AW         = 64,
   parameter int ATOM_BYTES = 32,
   parameter int MAX_BURST  = 8,
   parameter int LAT_DEPTH  = 64,
   parameter int BW         = $clog2(MAX_BURST)
) (
   input  logic                        nvdla_core_clk,
   input  logic                        nvdla_core_rstn,
   input  logic                        reg2dp_op_en,
   input  logic [AW-1:0]               reg2dp_base_addr,
   input  logic [AW-1:0]               reg2dp_line_stride,
   input  logic [AW-1:0]               reg2dp_surface_stride,
   input  logic [12:0]                 reg2dp_width,
   input  logic [12:0]                 reg2dp_height,
   input  logic [12:0]                 reg2dp_surfaces,
   input  logic [BW-1:0]               reg2dp_burst_len,
   input  logic                        reg2dp_perf_dma_en,
   nv_nvdla_sdp_rdma_req_gen_if.master req_if,
   input  logic                        lat_fifo_pop,
   output logic [31:0]                 dp2reg_rdma_stall,
   output logic                        dp2reg_done
);
   localparam int AL = $clog2(ATOM_BYTES);
   localparam int CW = $clog2(LAT_DEPTH + 1);
   localparam logic [CW-1:0] CRED_FULL  = CW'(LAT_DEPTH);
   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(ATOM_BYTES - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_state_n;

   logic [12:0]   r_atom_idx, r_line_cnt, r_surf_cnt;
   logic [AW-1:0] r_line_base, r_surf_base, r_addr;
   logic [BW-1:0] r_size;
   logic [CW-1:0] r_credits, w_credits_n;
   logic [31:0]   r_stall;

   logic [BW:0]   w_size_atoms;
   logic [13:0]   w_atom_end, w_line_atoms;
   logic          w_eol, w_eos, w_last, w_load, w_vld, w_accept;

   assign w_size_atoms = {1'b0, r_size} + {{BW{1'b0}}, 1'b1};
   assign w_line_atoms = {1'b0, reg2dp_width} + 14'd1;
   assign w_atom_end   = {1'b0, r_atom_idx} + 14'(w_size_atoms);
   assign w_eol        = (w_atom_end == w_line_atoms);
   assign w_eos        = w_eol && (r_line_cnt == reg2dp_height);
   assign w_last       = (r_state == S_REQ) && w_eos && (r_surf_cnt == reg2dp_surfaces);
   assign w_load       = (r_state == S_IDLE) && reg2dp_op_en;
   assign w_vld        = (r_state == S_REQ) && req_if.ig2cq_prdy && (r_credits >= CW'(w_size_atoms));
   assign w_accept     = w_vld && req_if.dma_rd_req_rdy;

   logic [12:0]   w_atom_n, w_line_n, w_surf_n;
   logic [AW-1:0] w_line_base_n, w_surf_base_n, w_addr_n;
   logic [13:0]   w_rem_n, w_sz_n;
`ifdef SDP_RDMA_4K_SPLIT_EN
   logic [13:0]   w_lim_4k;
`endif

   // Position of the next request; address and size are precomputed so they leave from registers.
   always_comb begin
      w_atom_n      = w_atom_end[12:0];
      w_line_n      = r_line_cnt;
      w_surf_n      = r_surf_cnt;
      w_line_base_n = r_line_base;
      w_surf_base_n = r_surf_base;
      if (w_load) begin
         w_atom_n      = '0;
         w_line_n      = '0;
         w_surf_n      = '0;
         w_surf_base_n = reg2dp_base_addr & ALIGN_MASK;
         w_line_base_n = w_surf_base_n;
      end else if (w_eos) begin
         w_atom_n      = '0;
         w_line_n      = '0;
         w_surf_n      = r_surf_cnt + 13'd1;
         w_surf_base_n = r_surf_base + (reg2dp_surface_stride & ALIGN_MASK);
         w_line_base_n = w_surf_base_n;
      end else if (w_eol) begin
         w_atom_n      = '0;
         w_line_n      = r_line_cnt + 13'd1;
         w_line_base_n = r_line_base + (reg2dp_line_stride & ALIGN_MASK);
      end
      w_addr_n = w_line_base_n + (AW'(w_atom_n) << AL);
      w_rem_n  = w_line_atoms - {1'b0, w_atom_n};
      w_sz_n   = 14'(reg2dp_burst_len) + 14'd1;
      if (w_rem_n < w_sz_n) w_sz_n = w_rem_n;
`ifdef SDP_RDMA_4K_SPLIT_EN
      w_lim_4k = 14'(4096 / ATOM_BYTES) - 14'(w_addr_n[11:AL]);
      if (w_lim_4k < w_sz_n) w_sz_n = w_lim_4k;
`endif
   end

   always_comb begin
      w_credits_n = r_credits;
      if (w_accept) w_credits_n = w_credits_n - CW'(w_size_atoms);
      if (lat_fifo_pop && (r_credits != CRED_FULL)) w_credits_n = w_credits_n + CW'(1);
   end

   // DRAIN looks at the next credit value so done follows the final pop by one cycle.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:  if (reg2dp_op_en) w_state_n = S_REQ;
         S_REQ:   if (w_accept && w_last) w_state_n = S_DRAIN;
         S_DRAIN: if (w_credits_n == CRED_FULL) w_state_n = S_DONE;
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         r_state     <= S_IDLE;
         r_atom_idx  <= '0;
         r_line_cnt  <= '0;
         r_surf_cnt  <= '0;
         r_line_base <= '0;
         r_surf_base <= '0;
         r_addr      <= '0;
         r_size      <= '0;
         r_credits   <= CRED_FULL;
         r_stall     <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_load || w_accept) begin
            r_atom_idx  <= w_atom_n;
            r_line_cnt  <= w_line_n;
            r_surf_cnt  <= w_surf_n;
            r_line_base <= w_line_base_n;
            r_surf_base <= w_surf_base_n;
            r_addr      <= w_addr_n;
            r_size      <= BW'(w_sz_n - 14'd1);
         end
         r_credits <= w_load ? CRED_FULL : w_credits_n;
         if (w_load) begin
            r_stall <= '0;
         end else if ((r_state == S_REQ || r_state == S_DRAIN) && reg2dp_perf_dma_en &&
                      w_vld && !req_if.dma_rd_req_rdy && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
         end
         if (lat_fifo_pop) assert (r_credits != CRED_FULL);
      end
   end

   assign req_if.dma_rd_req_vld  = w_vld;
   assign req_if.ig2cq_pvld      = w_vld;
   assign req_if.dma_rd_req_addr = r_addr;
   assign req_if.dma_rd_req_size = r_size;
   assign req_if.ig2cq_pd        = {w_last, r_size};
   assign dp2reg_rdma_stall      = r_stall;
   assign dp2reg_done            = (r_state == S_DONE);
endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_req_gen.sv
// tb/tb_nv_nvdla_sdp_rdma_req_gen.sv - directed bench for the SDP RDMA request generator
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_nv_nvdla_sdp_rdma_req_gen;
   localparam int AW         = 64;
   localparam int ATOM_BYTES = 32;
   localparam int MAX_BURST  = 8;
   localparam int LAT_DEPTH  = 16;
   localparam int BW         = 3;

   logic          clk = 1'b0;
   logic          rstn, rstn_v;
   logic          op_en, perf_en, lat_pop, done;
   logic [AW-1:0] base_addr, line_stride, surf_stride;
   logic [12:0]   width, height, surfaces;
   logic [BW-1:0] burst_len;
   logic [31:0]   stall;

   int n_err = 0;
   int n_chk = 0;
   int slot_no = 0;
   int done_cnt = 0;
   int done_slot = 0;
   int last_pop_slot = 0;
   int outst = 0;
   int load_slot = 0;
   logic          last_vld;
   logic [AW-1:0] q_addr[$];
   int            q_size[$];
   int            q_pd[$];
   int            q_slot[$];

   always #5 clk = ~clk;

   nv_nvdla_sdp_rdma_req_gen_if #(.AW(AW), .BW(BW)) bus ();

   nv_nvdla_sdp_rdma_req_gen #(
      .AW(AW), .ATOM_BYTES(ATOM_BYTES), .MAX_BURST(MAX_BURST), .LAT_DEPTH(LAT_DEPTH), .BW(BW)
   ) u_dut (
      .nvdla_core_clk        (clk),
      .nvdla_core_rstn       (rstn),
      .reg2dp_op_en          (op_en),
      .reg2dp_base_addr      (base_addr),
      .reg2dp_line_stride    (line_stride),
      .reg2dp_surface_stride (surf_stride),
      .reg2dp_width          (width),
      .reg2dp_height         (height),
      .reg2dp_surfaces       (surfaces),
      .reg2dp_burst_len      (burst_len),
      .reg2dp_perf_dma_en    (perf_en),
      .req_if                (bus),
      .lat_fifo_pop          (lat_pop),
      .dp2reg_rdma_stall     (stall),
      .dp2reg_done           (done)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic slot(input logic en, input logic rdy, input logic prdy, input logic pop);
      @(negedge clk);
      rstn                 = rstn_v;
      op_en                = en;
      bus.dma_rd_req_rdy   = rdy;
      bus.ig2cq_prdy       = prdy;
      lat_pop              = pop;
      if (pop) last_pop_slot = slot_no;
      #1;
      last_vld = bus.dma_rd_req_vld;
      if (rstn && bus.dma_rd_req_vld && rdy) begin
         q_addr.push_back(bus.dma_rd_req_addr);
         q_size.push_back(int'(bus.dma_rd_req_size));
         q_pd.push_back(int'(bus.ig2cq_pd));
         q_slot.push_back(slot_no);
         outst += int'(bus.dma_rd_req_size) + 1;
      end
      if (pop) outst--;
      if (done === 1'b1) begin
         done_cnt++;
         done_slot = slot_no;
      end
      slot_no++;
   endtask

   task automatic cfg(input logic [AW-1:0] b, input int w, input int h, input int s, input int bl,
                      input logic [AW-1:0] ls, input logic [AW-1:0] ss);
      base_addr   = b;
      width       = 13'(w);
      height      = 13'(h);
      surfaces    = 13'(s);
      burst_len   = BW'(bl);
      line_stride = ls;
      surf_stride = ss;
   endtask

   task automatic clear();
      q_addr.delete();
      q_size.delete();
      q_pd.delete();
      q_slot.delete();
      done_cnt = 0;
   endtask

   task automatic start_layer();
      clear();
      load_slot = slot_no;
      slot(1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic run_layer(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++)
         slot(1'b0, 1'b1, 1'b1, outst > 0);
   endtask

   task automatic check_req(input string tag, input int idx, input logic [63:0] a, input int s, input int p);
      if (idx >= q_addr.size()) begin
         check({tag, "_present"}, 64'd0, 64'd1);
      end else begin
         check({tag, "_addr"}, q_addr[idx], a);
         check({tag, "_size"}, 64'(q_size[idx]), 64'(s));
         check({tag, "_pd"}, 64'(q_pd[idx]), 64'(p));
      end
   endtask

   initial begin
      rstn = 1'b0; rstn_v = 1'b0; op_en = 1'b0; perf_en = 1'b0; lat_pop = 1'b0;
      bus.dma_rd_req_rdy = 1'b0; bus.ig2cq_prdy = 1'b0;
      cfg(64'h2000, 9, 0, 0, 3, 64'h0, 64'h0);

      slot(1'b0, 1'b0, 1'b1, 1'b0);
      slot(1'b0, 1'b0, 1'b1, 1'b0);
      check("rst_vld", 64'(bus.dma_rd_req_vld), 64'd0);
      check("rst_pvld", 64'(bus.ig2cq_pvld), 64'd0);
      check("rst_addr", bus.dma_rd_req_addr, 64'd0);
      check("rst_size", 64'(bus.dma_rd_req_size), 64'd0);
      check("rst_pd", 64'(bus.ig2cq_pd), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rstn_v = 1'b1;
      slot(1'b0, 1'b0, 1'b1, 1'b0);

      // Burst split along one line
      cfg(64'h2000, 9, 0, 0, 3, 64'h0, 64'h0);
      start_layer();
      run_layer(60);
      check("split_count", 64'(q_addr.size()), 64'd3);
      check_req("split0", 0, 64'h2000, 3, 3);
      check_req("split1", 1, 64'h2080, 3, 3);
      check_req("split2", 2, 64'h2100, 1, 9);
      if (q_slot.size() > 0) check("split_first_latency", 64'(q_slot[0] - load_slot), 64'd1);
      check("split_done_delay", 64'(done_slot - last_pop_slot), 64'd1);
      for (int i = 0; i < 3; i++) slot(1'b0, 1'b1, 1'b1, 1'b0);
      check("split_done_once", 64'(done_cnt), 64'd1);

      // Line and surface stride walk
      cfg(64'h0, 1, 1, 1, 7, 64'h100, 64'h1000);
      start_layer();
      run_layer(60);
      check("stride_count", 64'(q_addr.size()), 64'd4);
      check_req("stride0", 0, 64'h0000, 1, 1);
      check_req("stride1", 1, 64'h0100, 1, 1);
      check_req("stride2", 2, 64'h1000, 1, 1);
      check_req("stride3", 3, 64'h1100, 1, 9);
      check("stride_done", 64'(done_cnt), 64'd1);

      // Credit limit: 16 credits hold two 8-atom requests
      cfg(64'h0, 31, 0, 0, 7, 64'h0, 64'h0);
      start_layer();
      for (int i = 0; i < 4; i++) slot(1'b0, 1'b1, 1'b1, 1'b0);
      check("credit_two_reqs", 64'(q_addr.size()), 64'd2);
      check("credit_vld_low", 64'(last_vld), 64'd0);
      for (int i = 0; i < 8; i++) slot(1'b0, 1'b1, 1'b1, 1'b1);
      check("credit_vld_at_8th_pop", 64'(last_vld), 64'd0);
      check("credit_still_two", 64'(q_addr.size()), 64'd2);
      slot(1'b0, 1'b1, 1'b1, 1'b0);
      check("credit_vld_after_pop", 64'(last_vld), 64'd1);
      check_req("credit2", 2, 64'h200, 7, 7);
      run_layer(100);
      check_req("credit3", 3, 64'h300, 7, 15);
      check("credit_done", 64'(done_cnt), 64'd1);

      // 4 KB boundary
      cfg(64'hFC0, 3, 0, 0, 7, 64'h0, 64'h0);
      start_layer();
      run_layer(60);
`ifdef SDP_RDMA_4K_SPLIT_EN
      check("split4k_count", 64'(q_addr.size()), 64'd2);
      check_req("split4k0", 0, 64'hFC0, 1, 1);
      check_req("split4k1", 1, 64'h1000, 1, 9);
`else
      check("span4k_count", 64'(q_addr.size()), 64'd1);
      check_req("span4k0", 0, 64'hFC0, 3, 11);
`endif
      check("span4k_done", 64'(done_cnt), 64'd1);

      // Stall counting with perf enabled
      perf_en = 1'b1;
      cfg(64'h0, 7, 0, 0, 7, 64'h0, 64'h0);
      start_layer();
      for (int i = 0; i < 5; i++) slot(1'b0, 1'b0, 1'b1, 1'b0);
      check("stall_vld_held", 64'(last_vld), 64'd1);
      check("stall_pvld_held", 64'(bus.ig2cq_pvld), 64'd1);
      run_layer(60);
      check("stall_count5", 64'(stall), 64'd5);
      check("stall_done", 64'(done_cnt), 64'd1);

      // Perf disabled; ig2cq_prdy low blocks the request
      perf_en = 1'b0;
      start_layer();
      for (int i = 0; i < 3; i++) slot(1'b0, 1'b1, 1'b0, 1'b0);
      check("prdy_low_vld", 64'(last_vld), 64'd0);
      check("prdy_low_pvld", 64'(bus.ig2cq_pvld), 64'd0);
      check("prdy_low_no_req", 64'(q_addr.size()), 64'd0);
      for (int i = 0; i < 5; i++) slot(1'b0, 1'b0, 1'b1, 1'b0);
      run_layer(60);
      check("stall_off", 64'(stall), 64'd0);
      check("stall_off_reqs", 64'(q_addr.size()), 64'd1);

      // Reset in the middle of a layer
      perf_en = 1'b1;
      cfg(64'h0, 31, 0, 0, 7, 64'h0, 64'h0);
      start_layer();
      slot(1'b0, 1'b0, 1'b1, 1'b0);
      slot(1'b0, 1'b1, 1'b1, 1'b0);
      check("midrst_stall_before", 64'(stall), 64'd1);
      rstn_v = 1'b0;
      slot(1'b0, 1'b0, 1'b1, 1'b0);
      rstn_v = 1'b1;
      outst = 0;
      slot(1'b0, 1'b1, 1'b1, 1'b0);
      check("midrst_vld", 64'(last_vld), 64'd0);
      check("midrst_stall", 64'(stall), 64'd0);
      for (int i = 0; i < 4; i++) slot(1'b0, 1'b1, 1'b1, 1'b0);
      check("midrst_reqs", 64'(q_addr.size()), 64'd1);
      check("midrst_no_done", 64'(done_cnt), 64'd0);
      start_layer();
      run_layer(120);
      check("after_rst_reqs", 64'(q_addr.size()), 64'd4);
      check_req("after_rst0", 0, 64'h000, 7, 7);
      check("after_rst_done", 64'(done_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
